// File: rtl/rv_instr_mem_responder.sv
// rtl/rv_instr_mem_responder.sv - fixed-latency instruction memory responder with backdoor program load
module rv_instr_mem_responder #(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 1
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            instr_req_i,
    input  logic [XLEN-1:0] instr_addr_i,
    output logic            instr_rvalid_o,
    output logic [XLEN-1:0] instr_rdata_o,
    output logic            instr_err_o,
    input  logic            load_we_i,
    input  logic [XLEN-1:0] load_addr_i,
    input  logic [XLEN-1:0] load_wdata_i,
    output logic [31:0]     req_cnt_o
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [XLEN-1:0] r_mem [MEM_WORDS];
    logic            r_vld [LATENCY];
    logic [XLEN-1:0] r_data[LATENCY];
    logic            r_err [LATENCY];
    logic [31:0]     r_req_cnt;

    logic            w_req_in_range;
    logic            w_load_in_range;
    logic [AW-1:0]   w_req_idx;
    logic [AW-1:0]   w_load_idx;
    logic [XLEN-1:0] w_rd_word;
    logic            w_unused;

    // A word index is in range only when every index bit above the array size is zero.
    assign w_req_in_range  = (instr_addr_i[XLEN-1:AW+2] == '0);
    assign w_load_in_range = (load_addr_i[XLEN-1:AW+2] == '0);
    assign w_req_idx       = instr_addr_i[AW+1:2];
    assign w_load_idx      = load_addr_i[AW+1:2];
    assign w_rd_word       = r_mem[w_req_idx];
    assign w_unused        = ^{instr_addr_i[1:0], load_addr_i[1:0]};

    // Array is deliberately outside reset so program contents survive a core reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i && w_load_in_range) begin
            r_mem[w_load_idx] <= load_wdata_i;
        end
    end

    // Stage 0 samples the array at the acceptance edge, so a same-edge load is not visible.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_data[i] <= '0;
                r_err[i]  <= 1'b0;
            end
        end else begin
            r_vld[0]  <= instr_req_i;
            r_data[0] <= (instr_req_i && w_req_in_range) ? w_rd_word : '0;
            r_err[0]  <= instr_req_i && !w_req_in_range;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
                r_err[i]  <= r_err[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_req_cnt <= '0;
        end else if (instr_req_i && (r_req_cnt != 32'hFFFF_FFFF)) begin
            r_req_cnt <= r_req_cnt + 32'd1;
        end
    end

    assign instr_rvalid_o = r_vld[LATENCY-1];
    assign instr_rdata_o  = r_data[LATENCY-1];
    assign instr_err_o    = r_err[LATENCY-1];
    assign req_cnt_o      = r_req_cnt;

endmodule

// File: tb/tb_rv_instr_mem_responder.sv
// tb/tb_rv_instr_mem_responder.sv - directed bench with a due-time response queue model
module tb_rv_instr_mem_responder;
    localparam int MEM_WORDS = 1024;
    localparam int LAT       = 3;

    logic        clk;
    logic        arstn;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;
    logic [31:0] req_cnt;

    rv_instr_mem_responder #(
        .XLEN      (32),
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LAT)
    ) dut (
        .clk_i          (clk),
        .arstn_i        (arstn),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .load_we_i      (load_we),
        .load_addr_i    (load_addr),
        .load_wdata_i   (load_wdata),
        .req_cnt_o      (req_cnt)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mem_m [MEM_WORDS];
    logic [31:0] cnt_m;
    int          cyc;
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endfunction

    // Response model: each accepted request is due exactly LAT edges later.
    always @(negedge clk) begin
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_e;
        exp_v = 1'b0;
        exp_d = 32'h0;
        exp_e = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_v = 1'b1;
            exp_d = q[0].data;
            exp_e = q[0].err;
            q.delete(0);
        end
        chk("rvalid", {31'h0, instr_rvalid}, {31'h0, exp_v});
        chk("rdata", instr_rdata, exp_d);
        chk("err", {31'h0, instr_err}, {31'h0, exp_e});
        chk("req_cnt", req_cnt, cnt_m);
    end

    task automatic step(input logic req, input logic [31:0] addr, input logic we,
                        input logic [31:0] la, input logic [31:0] wd);
        resp_t r;
        @(negedge clk);
        #1;
        instr_req  = req;
        instr_addr = addr;
        load_we    = we;
        load_addr  = la;
        load_wdata = wd;
        if (req) begin
            r.due = cyc + LAT;
            if ((addr >> 2) < MEM_WORDS) begin
                r.data = mem_m[addr >> 2];
                r.err  = 1'b0;
            end else begin
                r.data = 32'h0;
                r.err  = 1'b1;
            end
            q.push_back(r);
        end
        @(posedge clk);
        if (we && ((la >> 2) < MEM_WORDS)) mem_m[la >> 2] = wd;
        if (req && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        instr_req = 1'b0;
        load_we   = 1'b0;
        arstn     = 1'b0;
        q.delete();
        cnt_m     = 32'h0;
        @(posedge clk);
        @(negedge clk);
        #1;
        arstn = 1'b1;
    endtask

    task automatic lit_at_resp(input string name, input logic [31:0] d, input logic e);
        @(negedge clk);
        #1;
        chk({name, "_v"}, {31'h0, instr_rvalid}, 32'h1);
        chk({name, "_d"}, instr_rdata, d);
        chk({name, "_e"}, {31'h0, instr_err}, {31'h0, e});
    endtask

    logic [31:0] load_data [8];
    logic [31:0] seq_addr [12];

    initial begin
        cyc        = 0;
        total      = 0;
        bad        = 0;
        cnt_m      = 32'h0;
        arstn      = 1'b0;
        instr_req  = 1'b0;
        instr_addr = 32'h0;
        load_we    = 1'b0;
        load_addr  = 32'h0;
        load_wdata = 32'h0;
        load_data  = '{32'h0000_0297, 32'h0040_0313, 32'h1111_1111, 32'h0000_3333,
                       32'h0000_4444, 32'h0000_0013, 32'h0000_6666, 32'h0000_7777};
        seq_addr   = '{32'h0000_0000, 32'h0000_0004, 32'h0000_1000, 32'h0000_0008,
                       32'h0000_000D, 32'hFFFF_FFFC, 32'h0000_0018, 32'h0000_0FFC,
                       32'h0000_001E, 32'h0000_1004, 32'h0000_0014, 32'h0000_0000};
        repeat (2) @(negedge clk);
        #1;
        chk("reset_cnt", req_cnt, 32'h0);
        chk("reset_rvalid", {31'h0, instr_rvalid}, 32'h0);
        arstn = 1'b1;

        // Program load; word 4 via an unaligned address, out-of-range write must not alias.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1, (i == 4) ? 32'h0000_0012 : i * 4, load_data[i]);
        end
        step(1'b0, 32'h0, 1'b1, 32'h0000_0FFC, 32'h7777_7777);
        step(1'b0, 32'h0, 1'b1, 32'h0000_1000, 32'hBAD0_BAD0);

        step(1'b1, 32'h0000_0014, 1'b0, 32'h0, 32'h0);
        idle(LAT - 1);
        lit_at_resp("word5", 32'h0000_0013, 1'b0);

        step(1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h0000_0004, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0);
        idle(LAT);
        chk("cnt_after_burst", req_cnt, 32'd4);

        step(1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0);
        idle(LAT - 1);
        lit_at_resp("oor", 32'h0, 1'b1);
        step(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 32'h0);
        idle(LAT - 1);
        lit_at_resp("last_word", 32'h7777_7777, 1'b0);

        step(1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        idle(LAT - 1);
        lit_at_resp("rbw_old", 32'h1111_1111, 1'b0);
        step(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0);
        idle(LAT - 1);
        lit_at_resp("rbw_new", 32'hDEAD_BEEF, 1'b0);

        // In-flight response must keep the data sampled at acceptance.
        step(1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'hCAFE_0000);
        idle(LAT);

        step(1'b1, 32'h0000_0013, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0);
        idle(LAT);

        for (int i = 0; i < 12; i++) begin
            step(1'b1, seq_addr[i], (i == 6), 32'h0000_0018, 32'h5A5A_0006);
        end
        idle(LAT + 1);

        step(1'b1, 32'h0000_0004, 1'b0, 32'h0, 32'h0);
        do_reset();
        idle(LAT + 2);
        @(negedge clk);
        #1;
        chk("post_reset_cnt", req_cnt, 32'h0);
        chk("post_reset_rvalid", {31'h0, instr_rvalid}, 32'h0);

        step(1'b1, 32'h0000_0014, 1'b0, 32'h0, 32'h0);
        idle(LAT - 1);
        lit_at_resp("after_reset", 32'h0000_0013, 1'b0);
        idle(2);

        chk("queue_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_instr_mem_responder.md
RV_INSTR_MEM_RESPONDER -- requirements
Module: rv_instr_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 32-bit words in the instruction array, power of two, 16..65536.
REQ-002 Parameter LATENCY, default 1: fixed cycles from request to response, legal range 1..4.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 arstn_i  input  1  reset, asynchronous, active-low.
REQ-005 instr_req_i  input  1  fetch request strobe; accepted every cycle it is high, no backpressure.
REQ-006 instr_addr_i  input  XLEN  byte address of requested instruction.
REQ-007 instr_rvalid_o  output  1  response valid, one-cycle pulse per accepted request.
REQ-008 instr_rdata_o  output  XLEN  instruction word, qualified by instr_rvalid_o.
REQ-009 instr_err_o  output  1  response targets out-of-range address, qualified by instr_rvalid_o.
REQ-010 load_we_i  input  1  backdoor write enable for program loading.
REQ-011 load_addr_i  input  XLEN  backdoor byte address.
REQ-012 load_wdata_i  input  XLEN  backdoor write data.
REQ-013 req_cnt_o  output  32  count of accepted requests since reset.

Function
REQ-014 Word index = addr[XLEN-1:2]; addr[1:0] ignored for reads and backdoor writes.
REQ-015 Address in range when word index < MEM_WORDS; otherwise out of range.
REQ-016 Request accepted in cycle N (instr_req_i high at edge N) produces instr_rvalid_o high exactly in cycle N+LATENCY, for one cycle.
REQ-017 Array read at acceptance edge; data carried through a LATENCY-deep pipeline of {valid, data, err} stages.
REQ-018 Back-to-back requests every cycle: one response per cycle, strictly in request order, no drops, no merges.
REQ-019 Out-of-range request: instr_rdata_o = 32'h0000_0000, instr_err_o = 1 in the response cycle.
REQ-020 In-range request: instr_err_o = 0, instr_rdata_o = array word.
REQ-021 instr_rdata_o and instr_err_o = 0 in every cycle instr_rvalid_o is 0.
REQ-022 load_we_i high with in-range load_addr_i: word written at the edge; out-of-range backdoor write ignored, no side effects.
REQ-023 Backdoor write and request to same word in same cycle: response returns old data (read-before-write); next request returns new data.
REQ-024 Backdoor writes do not alter responses already in flight.
REQ-025 req_cnt_o increments by 1 per accepted request, in-range or not; saturates at 32'hFFFF_FFFF, no wrap.
REQ-026 No internal state machine beyond pipeline valids; block is always ready.

Reset
REQ-027 arstn_i low: all pipeline valid bits, instr_rvalid_o, instr_err_o, instr_rdata_o, req_cnt_o cleared to 0 immediately.
REQ-028 Array contents not affected by reset; undefined until written.
REQ-029 Reset mid-operation: in-flight responses discarded, never delivered after reset release.
REQ-030 First request accepted at first rising edge with arstn_i high.

Verification
REQ-031 LATENCY=1, load word 5 = 32'h0000_0013, request addr 32'h14 at cycle N -> rvalid at N+1, rdata 32'h0000_0013, err 0.
REQ-032 LATENCY=3, requests 0x0, 0x4, 0x8 in consecutive cycles N..N+2 -> rvalid in N+3..N+5, words 0,1,2 in order; req_cnt_o = 3.
REQ-033 MEM_WORDS=1024, request addr 32'h0000_1000 -> rvalid after LATENCY, rdata 0, err 1; addr 32'h0FFC -> err 0.
REQ-034 Same cycle: backdoor write word 2 = 32'hDEAD_BEEF (old 32'h1111_1111) and request 0x8 -> response 32'h1111_1111; repeat request -> 32'hDEAD_BEEF.
REQ-035 LATENCY=2, request at N, arstn_i low during N+1 -> no rvalid in N+2 or later without new request; req_cnt_o = 0.
REQ-036 Request addr 32'h0000_0013 -> same response as addr 32'h0000_0010.
